muldiv_seq: RTL and testbench

- Iterative sequencer for the MIPS MULT/MULTU/DIV/DIVU HI/LO unit.
- Owns a 6-bit step counter: clears it at operation start, enables it once per iteration, and ends the run at terminal count.
- Drives one shift-add (multiply) or restoring (divide) step per cycle over unsigned magnitudes, applies sign fix-up, then presents HI/LO with a done pulse.
- Sits beside the ALU; the pipeline stalls on busy.

---
 rtl/muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative sequencer for the MIPS MULT/MULTU/DIV/DIVU HI/LO unit.
//   One shift-add (multiply) or restoring-divide step per RUN cycle over
//   unsigned magnitudes, followed by a sign fix-up and a one-cycle done pulse.
// Ports:
//   clk          rising-edge clock
//   clr          asynchronous active-high reset (aborts any operation)
//   start        operation request, accepted only in IDLE or DONE
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b         rs / rt operands (captured on start accept)
//   busy         high in PREP, RUN, FIXUP (pipeline stalls on it)
//   done         one-cycle pulse in DONE
//   div_by_zero  valid with done; set when a divide had b == 0
//   step         iteration counter (0..WIDTH-1 during RUN)
//   hi, lo       product high/low, or remainder/quotient
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [CNT_W-1:0] step,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIXUP, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Multiplicand magnitude (multiply) or divisor magnitude (divide).
    logic [WIDTH-1:0]   r_mb;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder (dividend was negative)
    logic [CNT_W-1:0]   r_step;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    logic               w_accept;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic               w_last;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div = r_op[1];
    assign w_a_neg  = r_op[0] & r_a[WIDTH-1];
    assign w_b_neg  = r_op[0] & r_b[WIDTH-1];
    // -0x80000000 is 0x80000000, which is the correct unsigned magnitude.
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);
    assign w_last   = (r_step == CNT_W'(WIDTH-1));

    // Multiply step: add multiplicand when the current multiplier LSB is set;
    // the carry becomes the new top bit after the right shift.
    assign w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mb} : '0);

    // Divide step: shift next dividend bit into the remainder and trial-subtract.
    // The remainder is always < divisor, so the shifted value fits WIDTH+1 bits
    // and the borrow (MSB of the difference) tells whether it went negative.
    assign w_shift  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff   = w_shift - {1'b0, r_mb};
    assign w_ge     = ~w_diff[WIDTH];

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and decoded outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PREP;
            S_PREP: begin
                busy   = 1'b1;
                w_next = (w_is_div && w_b_zero) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_FIXUP;
            end
            S_FIXUP: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = start ? S_PREP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mb     <= '0;
            r_acc    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_step   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_dbz <= 1'b0;
            end
            case (r_state)
                S_PREP: begin
                    r_step   <= '0;
                    r_neg_lo <= w_a_neg ^ w_b_neg;
                    r_neg_hi <= w_a_neg;
                    if (w_is_div) begin
                        r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mb  <= w_b_mag;
                    end else begin
                        r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                        r_mb  <= w_a_mag;
                    end
                    // Divide by zero skips the iterations and reports directly.
                    if (w_is_div && w_b_zero) begin
                        r_hi  <= r_a;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Counter stops at terminal count so it reads WIDTH-1 afterwards.
                    if (!w_last) r_step <= r_step + CNT_W'(1);
                    if (w_is_div)
                        r_acc <= {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                                  r_acc[WIDTH-2:0], w_ge};
                    else
                        r_acc <= {w_add, r_acc[WIDTH-1:1]};
                end
                S_FIXUP: begin
                    if (w_is_div) begin
                        r_lo <= r_neg_lo ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
                        r_hi <= r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end else begin
                        {r_hi, r_lo} <= r_neg_lo ? -r_acc : r_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign step        = r_step;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;
    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, dbz;
    logic [CW-1:0] step;
    logic [W-1:0]  hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(dbz), .step(step),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = o[0] ? longint'($signed(x)) : longint'({32'b0, x});
        sy = o[0] ? longint'($signed(y)) : longint'({32'b0, y});
        ed = 1'b0;
        if (!o[1]) begin
            p  = 64'(sx * sy);
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 0) begin
            ed = 1'b1;
            eh = x;
            el = '1;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issue one op (start in the current cycle) and check latency and results.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W-1:0] eh, el;
        logic ed;
        int n;
        model(o, x, y, eh, el, ed);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk({tag, ".lat"},  64'(n), ed ? 64'd2 : 64'd35);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".hi"},   64'(hi), 64'(eh));
        chk({tag, ".lo"},   64'(lo), 64'(el));
        chk({tag, ".dbz"},  64'(dbz), 64'(ed));
    endtask

    initial begin
        logic [W-1:0] eh, el, ph, pl;
        logic ed;
        int n, ndone;
        logic [1:0] ro;
        logic [W-1:0] rx, ry;

        clr = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dbz",  64'(dbz),  64'd0);
        chk("rst.step", 64'(step), 64'd0);
        chk("rst.hilo", {hi, lo},  64'd0);
        tick();
        clr = 1'b0;
        tick();

        // MULTU all-ones, cycle-by-cycle timeline
        op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            chk($sformatf("t1.busy%0d", k), 64'(busy), 64'(k <= 34));
            chk($sformatf("t1.done%0d", k), 64'(done), 64'(k == 35));
            if (k >= 2 && k <= 33) chk($sformatf("t1.step%0d", k), 64'(step), 64'(k - 2));
        end
        chk("t1.step_hold", 64'(step), 64'd31);
        chk("t1.hi", 64'(hi), 64'h0_FFFFFFFE);
        chk("t1.lo", 64'(lo), 64'h0_00000001);
        tick();
        chk("t1.done_pulse", 64'(done), 64'd0);

        // MULT -3*5, then back-to-back DIV -7/2 from the DONE cycle
        run_op(2'b01, 32'hFFFFFFFD, 32'd5, "t2m");
        chk("t2m.hi_c", 64'(hi), 64'hFFFFFFFF);
        chk("t2m.lo_c", 64'(lo), 64'hFFFFFFF1);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, "t2d");
        chk("t2d.lo_c", 64'(lo), 64'hFFFFFFFD);
        chk("t2d.hi_c", 64'(hi), 64'hFFFFFFFF);
        tick();

        // Divide by zero, then a multiply clears the flag
        run_op(2'b10, 32'h64, 32'd0, "t3z");
        chk("t3z.hi_c",  64'(hi),  64'h64);
        chk("t3z.lo_c",  64'(lo),  64'hFFFFFFFF);
        chk("t3z.dbz_c", 64'(dbz), 64'd1);
        tick();
        run_op(2'b00, 32'd2, 32'd3, "t3m");
        chk("t3m.lo_c",  64'(lo),  64'd6);
        chk("t3m.dbz_c", 64'(dbz), 64'd0);
        tick();

        // Overflowing signed divide wraps
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, "t4");
        chk("t4.lo_c", 64'(lo), 64'h80000000);
        chk("t4.hi_c", 64'(hi), 64'd0);
        tick();

        // start held with changing operands while busy is ignored
        ph = hi; pl = lo;
        model(2'b01, 32'h12345678, 32'hFEDCBA98, eh, el, ed);
        op = 2'b01; a = 32'h12345678; b = 32'hFEDCBA98; start = 1'b1;
        tick();
        n = 1; ndone = 0;
        while (!done && n < 60) begin
            op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            tick();
            n++;
            if (n == 5) chk("t5.hold_hilo", {hi, lo}, {ph, pl});
        end
        start = 1'b0;
        if (done) ndone++;
        chk("t5.lat", 64'(n), 64'd35);
        chk("t5.hi",  64'(hi), 64'(eh));
        chk("t5.lo",  64'(lo), 64'(el));
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("t5.ndone", 64'(ndone), 64'd1);

        // Randomized ops, mixing back-to-back and gapped starts
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFFFFFF;
                default: ry = 32'($urandom);
            endcase
            run_op(ro, rx, ry, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // clr mid-run aborts without done
        op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!(busy && step == 6'd10) && n < 60) begin
            tick();
            n++;
        end
        chk("t6.reach10", 64'(step), 64'd10);
        #2 clr = 1'b1;
        #1;
        chk("t6.busy", 64'(busy), 64'd0);
        chk("t6.step", 64'(step), 64'd0);
        chk("t6.hilo", {hi, lo},  64'd0);
        chk("t6.done", 64'(done), 64'd0);
        tick();
        clr = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("t6.nodone", 64'(ndone), 64'd0);
        run_op(2'b10, 32'd100, 32'd7, "t6d");
        chk("t6d.lo_c", 64'(lo), 64'd14);
        chk("t6d.hi_c", 64'(hi), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
